qam_symbol_scheduler: RTL and testbench

Controller that sequences the modulator's transmit word FIFO into a fixed-rate stream of 4-bit QAM symbols. It waits for the FIFO to prefill, prefetches 16-bit words, and emits one nibble per programmable symbol period, low nibble first. On starvation it inserts idle symbols and counts underruns. Runtime configuration arrives as UART packets addressed to its own destination byte. It sits between the UART packet receiver, the word FIFO read port and the QAM mapper.

---
 rtl/qam_symbol_scheduler_pkg.sv | 33 +++
 rtl/qam_symbol_scheduler_tick.sv | 34 +++
 rtl/qam_symbol_scheduler.sv | 175 +++++++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_symbol_scheduler_pkg.sv
// rtl/qam_symbol_scheduler_pkg.sv - shared types and register map for the QAM symbol scheduler
package qam_symbol_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } SCHED_STATE;

    typedef enum logic [1:0] {
        P_WAIT,
        P_DLO,
        P_DHI,
        P_SKIP
    } PARSE_STATE;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [7:0] destination;
        logic [7:0] data;
    } UART_PACKET;

    localparam logic [7:0] REG_PERIOD = 8'd0;
    localparam logic [7:0] REG_WMARK  = 8'd1;
    localparam logic [7:0] REG_CTRL   = 8'd2;

    localparam int CTRL_ENABLE       = 0;
    localparam int CTRL_CLR_UNDERRUN = 1;

endpackage

// File: rtl/qam_symbol_scheduler_tick.sv
// rtl/qam_symbol_scheduler_tick.sv - symbol period counter producing one tick per period
module symbol_tick_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        clear,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] count;
    logic [15:0] periodCur;

    assign tick = run && (count == periodCur - 16'd1);

    // Period is only sampled while cleared or on wrap, so mid-symbol writes wait for the reload.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count     <= '0;
            periodCur <= '0;
        end else if (clear) begin
            count     <= '0;
            periodCur <= period;
        end else if (run) begin
            if (tick) begin
                count     <= '0;
                periodCur <= period;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// rtl/qam_symbol_scheduler.sv - sequences FIFO words into a fixed-rate 4-bit QAM symbol stream
module qam_symbol_scheduler
    import qam_symbol_scheduler_pkg::*;
#(
    parameter logic [7:0]  CFG_DEST       = 8'h11,
    parameter logic [15:0] PERIOD_DEFAULT = 16'd567,
    parameter logic [15:0] PERIOD_MIN     = 16'd4,
    parameter logic [12:0] WMARK_DEFAULT  = 13'd4,
    parameter logic [3:0]  IDLE_SYMBOL    = 4'h0
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  UART_PACKET  ipRxStream,
    input  logic [12:0] ipFifoCount,
    input  logic        ipFifoEmpty,
    input  logic [15:0] ipFifoData,
    output logic        opFifoRdEn,
    output logic [3:0]  opSymbol,
    output logic        opSymbolValid,
    output logic        opUnderrun,
    output logic [7:0]  opUnderrunCount,
    output logic [1:0]  opState
);

    SCHED_STATE state, nextState;
    PARSE_STATE parseState;

    logic [15:0] period;
    logic [12:0] wmark;
    logic        enable;
    logic [7:0]  cfgAddr;
    logic [7:0]  cfgLo;
    logic [15:0] cfgValue;
    logic        commit;
    logic        clrUnderrun;

    logic        active;
    logic        tick;
    logic        rdPending;
    logic        nextValid;
    logic [15:0] nextWord;
    logic [15:0] curWord;
    logic [1:0]  nibbleIdx;
    logic        drainDone;

    assign commit      = ipRxStream.valid && !ipRxStream.sop && (parseState == P_DHI);
    assign cfgValue    = {ipRxStream.data, cfgLo};
    assign clrUnderrun = commit && (cfgAddr == REG_CTRL) && cfgValue[CTRL_CLR_UNDERRUN];

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            parseState <= P_WAIT;
            cfgAddr    <= '0;
            cfgLo      <= '0;
        end else if (ipRxStream.valid) begin
            if (ipRxStream.sop) begin
                cfgAddr    <= ipRxStream.data;
                parseState <= (ipRxStream.destination == CFG_DEST && !ipRxStream.eop) ? P_DLO : P_WAIT;
            end else begin
                case (parseState)
                    P_DLO: begin
                        cfgLo      <= ipRxStream.data;
                        parseState <= ipRxStream.eop ? P_WAIT : P_DHI;
                    end
                    P_DHI:   parseState <= ipRxStream.eop ? P_WAIT : P_SKIP;
                    P_SKIP:  if (ipRxStream.eop) parseState <= P_WAIT;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            period <= PERIOD_DEFAULT;
            wmark  <= WMARK_DEFAULT;
            enable <= 1'b0;
        end else if (commit) begin
            case (cfgAddr)
                REG_PERIOD: period <= (cfgValue < PERIOD_MIN) ? PERIOD_MIN : cfgValue;
                REG_WMARK:  wmark  <= (cfgValue[12:0] == 13'd0) ? 13'd1 : cfgValue[12:0];
                REG_CTRL:   enable <= cfgValue[CTRL_ENABLE];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (!ipReset) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (enable) nextState = PREFILL;
            PREFILL: begin
                if (!enable)                    nextState = IDLE;
                else if (ipFifoCount >= wmark)  nextState = RUN;
            end
            RUN:     if (!enable) nextState = DRAIN;
            DRAIN:   if (drainDone || (tick && nibbleIdx == 2'd0)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        opState    = state;
        active     = (state == RUN) || (state == DRAIN);
        opFifoRdEn = (state == RUN) && !nextValid && !rdPending && !ipFifoEmpty;
    end

    symbol_tick_gen u_tick (
        .clk    (ipClk),
        .resetn (ipReset),
        .run    (active),
        .clear  (!active),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            rdPending       <= 1'b0;
            nextValid       <= 1'b0;
            nextWord        <= '0;
            curWord         <= '0;
            nibbleIdx       <= '0;
            drainDone       <= 1'b0;
            opSymbol        <= '0;
            opSymbolValid   <= 1'b0;
            opUnderrun      <= 1'b0;
            opUnderrunCount <= '0;
        end else begin
            opSymbolValid <= 1'b0;
            opUnderrun    <= 1'b0;
            drainDone     <= 1'b0;
            if (!active) begin
                // Leaving RUN/DRAIN flushes any prefetched word.
                rdPending <= 1'b0;
                nextValid <= 1'b0;
                nibbleIdx <= '0;
            end else begin
                rdPending <= opFifoRdEn;
                if (rdPending && !(tick && nibbleIdx == 2'd0 && state == RUN)) begin
                    nextWord  <= ipFifoData;
                    nextValid <= 1'b1;
                end
                if (tick) begin
                    if (nibbleIdx != 2'd0) begin
                        opSymbol      <= curWord[{nibbleIdx, 2'b00} +: 4];
                        opSymbolValid <= 1'b1;
                        nibbleIdx     <= nibbleIdx + 2'd1;
                        drainDone     <= (state == DRAIN) && (nibbleIdx == 2'd3);
                    end else if (state == RUN) begin
                        opSymbolValid <= 1'b1;
                        if (nextValid || rdPending) begin
                            // A read landing on this tick bypasses the next buffer.
                            curWord   <= nextValid ? nextWord : ipFifoData;
                            opSymbol  <= nextValid ? nextWord[3:0] : ipFifoData[3:0];
                            nibbleIdx <= 2'd1;
                            nextValid <= 1'b0;
                        end else begin
                            opSymbol   <= IDLE_SYMBOL;
                            opUnderrun <= 1'b1;
                            if (opUnderrunCount != 8'hFF) opUnderrunCount <= opUnderrunCount + 8'd1;
                        end
                    end
                end
            end
            if (clrUnderrun) opUnderrunCount <= '0;
        end
    end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb/tb_qam_symbol_scheduler.sv - directed bench with a word/nibble queue model of the scheduler
module tb_qam_symbol_scheduler;
    import qam_symbol_scheduler_pkg::*;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b0;
    UART_PACKET  ipRxStream = '0;
    logic [12:0] ipFifoCount = '0;
    logic        ipFifoEmpty = 1'b1;
    logic [15:0] ipFifoData = '0;
    logic        opFifoRdEn;
    logic [3:0]  opSymbol;
    logic        opSymbolValid;
    logic        opUnderrun;
    logic [7:0]  opUnderrunCount;
    logic [1:0]  opState;

    always #5 ipClk = ~ipClk;

    qam_symbol_scheduler dut (
        .ipClk           (ipClk),
        .ipReset         (ipReset),
        .ipRxStream      (ipRxStream),
        .ipFifoCount     (ipFifoCount),
        .ipFifoEmpty     (ipFifoEmpty),
        .ipFifoData      (ipFifoData),
        .opFifoRdEn      (opFifoRdEn),
        .opSymbol        (opSymbol),
        .opSymbolValid   (opSymbolValid),
        .opUnderrun      (opUnderrun),
        .opUnderrunCount (opUnderrunCount),
        .opState         (opState)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] fifoQ[$];
    logic [3:0]  expNib[$];
    logic [3:0]  symLog[$];
    int          symCyc[$];
    int          expRd = 0;
    int          symCount = 0;
    int          rdPulses = 0;
    int          lastSym = 0;
    int          mPeriodReg = 567;
    int          mEff = 567;
    logic [1:0]  prevState = 2'd0;
    logic        rdSeen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour: nibbles leave low-first in word order, spaced by the period in force at the last reload.
    task automatic compareCycle();
        if (prevState == 2'd1 && opState == 2'd2) begin
            lastSym = cyc;
            mEff    = mPeriodReg;
        end
        if (opUnderrun) check("underrun_needs_valid_in_run", {29'd0, opSymbolValid, opState}, {29'd0, 1'b1, 2'd2});
        if (opSymbolValid) begin
            check("valid_only_in_run_or_drain", 32'(opState >= 2'd2), 32'd1);
            check("symbol_gap", cyc - lastSym, mEff);
            lastSym = cyc;
            mEff    = mPeriodReg;
            if (opUnderrun) begin
                check("underrun_symbol", opSymbol, 4'h0);
                check("underrun_with_data_pending", expNib.size() - expRd, 0);
            end else begin
                check("symbol_data_available", 32'(expRd < expNib.size()), 32'd1);
                if (expRd < expNib.size()) begin
                    check("symbol_value", opSymbol, expNib[expRd]);
                    expRd++;
                end
            end
            symLog.push_back(opSymbol);
            symCyc.push_back(cyc);
            symCount++;
        end
        prevState = opState;
    endtask

    task automatic syncFlags();
        ipFifoCount = 13'(fifoQ.size());
        ipFifoEmpty = (fifoQ.size() == 0);
    endtask

    task automatic step();
        @(negedge ipClk);
        compareCycle();
        rdSeen = opFifoRdEn;
        if (rdSeen) rdPulses++;
        @(posedge ipClk);
        cyc++;
        #1;
        if (rdSeen && fifoQ.size() > 0) ipFifoData = fifoQ.pop_front();
        syncFlags();
    endtask

    task automatic pushWord(input logic [15:0] w);
        fifoQ.push_back(w);
        for (int k = 0; k < 4; k++) expNib.push_back(w[4*k +: 4]);
        syncFlags();
    endtask

    task automatic doReset();
        ipReset    = 1'b0;
        ipRxStream = '0;
        step();
        ipReset = 1'b1;
        fifoQ.delete();
        expNib.delete();
        symLog.delete();
        symCyc.delete();
        expRd      = 0;
        symCount   = 0;
        rdPulses   = 0;
        mPeriodReg = 567;
        mEff       = 567;
        prevState  = 2'd0;
        syncFlags();
    endtask

    task automatic sendPacket(input logic [7:0] dest, input logic [23:0] bytesLe, input int n);
        for (int i = 0; i < n; i++) begin
            ipRxStream.valid       = 1'b1;
            ipRxStream.sop         = (i == 0);
            ipRxStream.eop         = (i == n - 1);
            ipRxStream.destination = dest;
            ipRxStream.data        = bytesLe[8*i +: 8];
            step();
        end
        ipRxStream = '0;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [15:0] val);
        sendPacket(8'h11, {val[15:8], val[7:0], addr}, 3);
        if (addr == 8'd0) mPeriodReg = (val < 16'd4) ? 4 : int'(val);
    endtask

    task automatic waitSymbols(input string name, input int n, input int budget);
        int target = symCount + n;
        int t = 0;
        while (symCount < target && t < budget) begin
            step();
            t++;
        end
        check(name, 32'(symCount >= target), 32'd1);
    endtask

    task automatic waitState(input string name, input logic [1:0] s, input int budget);
        int t = 0;
        while (opState != s && t < budget) begin
            step();
            t++;
        end
        check(name, opState, s);
    endtask

    task automatic checkOutputsZero();
        check("rst_state", opState, 2'd0);
        check("rst_symbol", opSymbol, 4'h0);
        check("rst_symbol_valid", opSymbolValid, 1'b0);
        check("rst_underrun", opUnderrun, 1'b0);
        check("rst_underrun_count", opUnderrunCount, 8'd0);
        check("rst_fifo_rd", opFifoRdEn, 1'b0);
    endtask

    initial begin
        logic [31:0] packed8;
        int n0;

        // Prefill watermark, then two words emitted low nibble first at period 8.
        doReset();
        checkOutputsZero();
        writeReg(8'd0, 16'd8);
        writeReg(8'd1, 16'd2);
        writeReg(8'd2, 16'd1);
        step();
        check("enable_to_prefill", opState, 2'd1);
        pushWord(16'hABCD);
        step();
        step();
        check("below_watermark_holds", opState, 2'd1);
        pushWord(16'h1234);
        waitState("reach_run", 2'd2, 10);
        waitSymbols("wait_eight_symbols", 8, 100);
        packed8 = '0;
        for (int i = 0; i < 8 && i < symLog.size(); i++) packed8[4*i +: 4] = symLog[i];
        check("first_eight_symbols", packed8, 32'h1234ABCD);

        // Single word then starvation, underrun counter and its clear.
        doReset();
        writeReg(8'd0, 16'd8);
        writeReg(8'd1, 16'd1);
        writeReg(8'd2, 16'd1);
        pushWord(16'h00F0);
        waitSymbols("wait_underruns", 7, 90);
        packed8 = '0;
        for (int i = 0; i < 4 && i < symLog.size(); i++) packed8[4*i +: 4] = symLog[i];
        check("word_00f0_nibbles", packed8, 32'h0000_00F0);
        check("underrun_count_3", opUnderrunCount, 8'd3);
        writeReg(8'd2, 16'h0003);
        check("underrun_count_cleared", opUnderrunCount, 8'd0);
        check("enable_kept_after_clear", opState, 2'd2);
        waitSymbols("wait_underrun_after_clear", 1, 20);
        check("underrun_count_1", opUnderrunCount, 8'd1);

        // Period clamp, then a mid-word period change applied at the next reload.
        doReset();
        writeReg(8'd0, 16'd2);
        writeReg(8'd1, 16'd1);
        writeReg(8'd2, 16'd1);
        pushWord(16'hABCD);
        pushWord(16'h1234);
        waitSymbols("wait_first_fast", 1, 40);
        step();
        writeReg(8'd0, 16'd16);
        waitSymbols("wait_after_period16", 5, 200);
        if (symCyc.size() >= 4) begin
            check("clamped_spacing_4", symCyc[1] - symCyc[0], 4);
            check("period16_spacing", symCyc[3] - symCyc[2], 16);
        end

        // Disable after nibble 1: remaining nibbles drain, then IDLE with the prefetch discarded.
        doReset();
        writeReg(8'd0, 16'd8);
        writeReg(8'd1, 16'd1);
        writeReg(8'd2, 16'd1);
        pushWord(16'hABCD);
        pushWord(16'h1234);
        waitSymbols("wait_d_c", 2, 60);
        writeReg(8'd2, 16'd0);
        n0 = symCount;
        waitState("drain_to_idle", 2'd0, 60);
        check("drain_symbol_count", symCount - n0, 2);
        if (symLog.size() >= 4) check("drain_symbols_b_a", {symLog[3], symLog[2]}, 8'hAB);
        check("drain_word_boundary", expRd, 4);
        check("fifo_read_pulses", rdPulses, 2);
        n0 = symCount;
        repeat (30) step();
        check("no_symbols_in_idle", symCount - n0, 0);

        // Reset mid-RUN, then ignored packets leave the default period in place.
        doReset();
        writeReg(8'd0, 16'd8);
        writeReg(8'd1, 16'd1);
        writeReg(8'd2, 16'd1);
        pushWord(16'hABCD);
        waitSymbols("wait_before_reset", 2, 40);
        doReset();
        checkOutputsZero();
        sendPacket(8'h10, 24'h000800, 3);
        sendPacket(8'h11, 24'h000800, 2);
        writeReg(8'd1, 16'd1);
        writeReg(8'd2, 16'd1);
        pushWord(16'h5A5A);
        waitSymbols("wait_default_period", 2, 2 * 567 + 40);
        if (symCyc.size() >= 2) check("default_spacing_567", symCyc[1] - symCyc[0], 567);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
